debug_uart_tx: RTL
==================

Name: debug_uart_tx

Overview:
Serial back-end for the debug subsystem. Sits directly downstream of the debug slave inside the Avalon RISC-V top: it consumes each tx_flag pulse with its 32-bit debug word and emits the word as BYTES 8N1 UART frames on a single pin. When the last frame finishes, it returns doneSending so the debug block can issue the next word. One clock; asynchronous active-low reset.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer division, DIV >= 2 enforced by elaboration assertion)
BYTES, 4, bytes sent per word, range 1..4, least significant byte first

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous reset, active low
tx_flag  input  1  one-cycle request: send tx_data
tx_data  input  32  debug word; sampled only on an accepted tx_flag
doneSending  output  1  one-cycle pulse after the last stop bit of the word
busy  output  1  high from acceptance until the last stop bit ends
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset: state IDLE, uart_tx=1, busy=0, doneSending=0, bit/byte/baud counters=0, shift register=0. Asynchronous assert; all registers leave reset on the first CLK edge after RST_N rises.
- Acceptance: tx_flag is accepted when busy=0, in IDLE or DONE. On acceptance, tx_data is latched into a 32-bit shadow register, byte_idx=0, and the FSM goes to START. tx_flag while busy=1 is ignored (no queueing) and must not corrupt the transfer.
- Bit timing: each bit is held for exactly DIV cycles by a baud counter counting 0..DIV-1. The counter is reloaded to 0 on every state entry. uart_tx is registered.
- FSM states:
  - IDLE: uart_tx=1.
  - START: uart_tx=0 for DIV cycles, then DATA with bit_idx=0.
  - DATA: uart_tx = byte[bit_idx], LSB first. Increment bit_idx after each DIV cycles. After bit 7, go to PARITY if the feature is enabled, else STOP.
  - STOP: uart_tx=1 for DIV cycles. Then, if byte_idx==BYTES-1, go to DONE; else increment byte_idx and go to START. There is no idle gap between bytes.
  - DONE: lasts one cycle. doneSending=1, busy=0. Next state is IDLE, or START if tx_flag is present in this cycle.
- Byte select: byte = shadow[8*byte_idx +: 8]. byte_idx is 2 bits and never wraps past BYTES-1.
- Latency: the first falling edge of uart_tx is visible one cycle after the tx_flag cycle. doneSending is asserted BYTES*F*DIV+1 cycles after the tx_flag cycle, where F=10 (F=11 with parity).
- busy rises the cycle after acceptance and falls in DONE.
- Reset mid-frame: the frame is abandoned, uart_tx returns high immediately, and no doneSending is produced.

Optional Feature:
DEBUG_UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles, which makes F=11.
- Undefined: no PARITY state and no parity logic; framing is 8N1 with F=10.

Decomposition:
- Package debug_uart_pkg holds:
  - typedef enum logic [2:0] uart_state_t {IDLE, START, DATA, PARITY, STOP, DONE}
  - function calc_div(clk_freq, baud)
  - localparam FRAME_BITS, dependent on the macro
- Sub-module baud_tick_gen #(DIV): inputs CLK, RST_N, clr; output tick, asserted on count==DIV-1. The FSM instantiates one.

Test Plan (CLK_FREQ=1000000, BAUD=100000 so DIV=10, BYTES=4, no parity unless stated):
1. Reset held, then released → uart_tx=1, busy=0, doneSending=0 for 50 cycles.
2. tx_flag with tx_data=0xA5C30F81 → line decodes bytes 0x81, 0x0F, 0xC3, 0xA5; each bit lasts 10 cycles; doneSending pulses exactly 401 cycles after tx_flag, for 1 cycle.
3. Second tx_flag with 0xFFFFFFFF at cycle 150 of that transfer → ignored; output still 0xA5C30F81.
4. tx_flag in the DONE cycle with 0x00000000 → START entered with no idle cycle; four 0x00 frames follow.
5. RST_N pulsed low at cycle 200 of a transfer → uart_tx=1 in the same cycle, no doneSending, next tx_flag 0x12345678 transmits correctly.
6. DEBUG_UART_PARITY_EN defined, tx_data=0x00000007, BYTES=1 → frame 0, 1,1,1,0,0,0,0,0, parity 1, stop 1; doneSending at cycle 111.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: shared types and constants for the debug UART transmitter.
// Optional feature macro: DEBUG_UART_PARITY_EN (adds an even-parity bit per frame).
package debug_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} uart_state_t;

`ifdef DEBUG_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/debug_uart_tx_baud_tick_gen.sv
// baud_tick_gen: free-running bit-period counter, 0..DIV-1.
// Ports:
//   CLK   - system clock, rising edge
//   RST_N - asynchronous reset, active low
//   clr   - synchronous restart of the count at 0
//   tick  - high while the count is DIV-1 (last cycle of a bit)
module baud_tick_gen #(
  parameter int DIV = 434
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: sends each accepted 32-bit debug word as BYTES UART frames,
// least significant byte first, then pulses doneSending for one cycle.
// Optional feature macro: DEBUG_UART_PARITY_EN (8E1 instead of 8N1).
// Ports:
//   CLK, RST_N  - clock (rising edge), asynchronous active-low reset
//   tx_flag     - one-cycle send request, accepted only when not busy
//   tx_data     - word to send, latched on acceptance
//   doneSending - one-cycle pulse after the last stop bit
//   busy        - transfer in progress
//   uart_tx     - registered serial line, idle high
//
// state  | meaning
// IDLE   | line idle high, waiting for tx_flag
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (1); next byte or DONE
// DONE   | one cycle, doneSending=1, may accept a new word
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int BYTES    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        tx_flag,
  input  logic [31:0] tx_data,
  output logic        doneSending,
  output logic        busy,
  output logic        uart_tx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  if (DIV < 2) begin : g_div_chk
    $error("debug_uart_tx: CLK_FREQ/BAUD must be >= 2");
  end
  if (BYTES < 1 || BYTES > 4) begin : g_bytes_chk
    $error("debug_uart_tx: BYTES must be 1..4");
  end

  uart_state_t r_state, w_state_nxt;
  logic [31:0] r_shadow;
  logic [2:0]  r_bit_idx, w_bit_nxt;
  logic [1:0]  r_byte_idx, w_byte_nxt;
  logic        r_tx, w_tx_nxt;
  logic        w_tick, w_clr, w_accept;
  logic [7:0]  w_byte;

  // Bit counter restarts on every state entry, and is held at 0 while idle.
  assign w_clr    = (w_state_nxt != r_state) || (r_state == IDLE);
  assign w_accept = tx_flag && ((r_state == IDLE) || (r_state == DONE));
  assign w_byte   = r_shadow[{r_byte_idx, 3'b000} +: 8];

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    case (r_state)
      IDLE, DONE: begin
        if (tx_flag) begin
          w_state_nxt = START;
          w_byte_nxt  = 2'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'd7) begin
`ifdef DEBUG_UART_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef DEBUG_UART_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_nxt = DONE;
          end else begin
            w_byte_nxt  = r_byte_idx + 2'd1;
            w_state_nxt = START;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line value is computed from the next state so the registered pin changes
  // on the same edge as the state; the byte index only moves while entering
  // START, where the line is 0 regardless of the byte.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_byte[w_bit_nxt];
`ifdef DEBUG_UART_PARITY_EN
      PARITY:  w_tx_nxt = ^w_byte;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_tx       <= w_tx_nxt;
      if (w_accept) r_shadow <= tx_data;
    end
  end

  assign uart_tx     = r_tx;
  assign busy        = (r_state != IDLE) && (r_state != DONE);
  assign doneSending = (r_state == DONE);

endmodule
